// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// FSM state encoding and the ALU opcode set.
package alu_share_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU shared by all requesters.
// Ports: SrcA/SrcB operands, ALUControl opcode, ALUResult, Zero flag.
module alu
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [2:0]            ALUControl,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    logic [DATA_WIDTH-1:0] diff;

    assign diff = SrcA - SrcB;

    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_SUB: ALUResult = diff;
            ALU_MUL: ALUResult = SrcA * SrcB;
            // Sign bit of the difference, zero-extended.
            ALU_SLT: ALUResult = {{(DATA_WIDTH-1){1'b0}}, diff[DATA_WIDTH-1]};
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter starting its search at Ptr.
// Ports: Req vector, Ptr start index, one-hot Grant, encoded GrantId.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] Req,
    input  logic [PW-1:0]      Ptr,
    output logic [NUM_REQ-1:0] Grant,
    output logic [PW-1:0]      GrantId
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        Grant   = '0;
        GrantId = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Ptr < NUM_REQ and k < NUM_REQ, so one subtraction wraps it.
            sum = {1'b0, Ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (!found && Req[idx]) begin
                found      = 1'b1;
                Grant[idx] = 1'b1;
                GrantId    = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept,
// latched operands, one EXEC cycle, registered response with valid/ready.
// Ports: clk, reset (async high); ReqValid/ReqReady/ReqSrcA/ReqSrcB/
// ReqALUControl request side; RspValid/RspReady/RspResult/RspZero/RspId
// response side; Busy high while an operation is in flight.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            ReqValid,
    output logic [NUM_REQ-1:0]            ReqReady,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqSrcA,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqSrcB,
    input  logic [NUM_REQ*3-1:0]          ReqALUControl,
    output logic [NUM_REQ-1:0]            RspValid,
    input  logic [NUM_REQ-1:0]            RspReady,
    output logic [DATA_WIDTH-1:0]         RspResult,
    output logic                          RspZero,
    output logic [ID_WIDTH-1:0]           RspId,
    output logic                          Busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         ptr_next;
    logic [DATA_WIDTH-1:0] lat_a;
    logic [DATA_WIDTH-1:0] lat_b;
    logic [2:0]            lat_op;
    logic [PW-1:0]         lat_id;
    logic [NUM_REQ-1:0]    grant;
    logic [PW-1:0]         grant_id;
    logic                  accept;
    logic                  rsp_done;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_zero;

    logic [DATA_WIDTH-1:0] src_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] src_b [NUM_REQ];
    logic [2:0]            src_op [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign src_a[i]  = ReqSrcA[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_b[i]  = ReqSrcB[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_op[i] = ReqALUControl[i*3 +: 3];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .Req     (ReqValid),
        .Ptr     (rr_ptr),
        .Grant   (grant),
        .GrantId (grant_id)
    );

    // Fed only from the latches so requester operands may change freely.
    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .SrcA       (lat_a),
        .SrcB       (lat_b),
        .ALUControl (lat_op),
        .ALUResult  (alu_res),
        .Zero       (alu_zero)
    );

    assign accept   = (state == ST_IDLE) && (|grant);
    assign rsp_done = (state == ST_RESP) && RspReady[lat_id];
    assign ptr_next = (lat_id == PW'(NUM_REQ-1)) ? '0 : lat_id + PW'(1);
    assign RspId    = ID_WIDTH'(lat_id);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (accept)   next_state = ST_EXEC;
            ST_EXEC:               next_state = ST_RESP;
            ST_RESP: if (rsp_done) next_state = ST_IDLE;
            default:               next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ReqReady = '0;
        RspValid = '0;
        Busy     = 1'b0;
        unique case (state)
            // Gated by reset so nothing is offered while held in reset.
            ST_IDLE: ReqReady = reset ? '0 : grant;
            ST_EXEC: Busy = 1'b1;
            ST_RESP: begin
                Busy             = 1'b1;
                RspValid[lat_id] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_op    <= '0;
            lat_id    <= '0;
            RspResult <= '0;
            RspZero   <= 1'b0;
        end else begin
            if (accept) begin
                lat_a  <= src_a[grant_id];
                lat_b  <= src_b[grant_id];
                lat_op <= src_op[grant_id];
                lat_id <= grant_id;
            end
            if (state == ST_EXEC) begin
                RspResult <= alu_res;
                RspZero   <= alu_zero;
            end
            if (rsp_done)
                rr_ptr <= ptr_next;
        end
    end

endmodule
